// File: rtl/io_init_spi_seq.sv
// io_init_spi_seq: SPI register-initialisation sequencer.
// Plays words from a runtime-writable two-bank table out over SPI (MSB first),
// with an optional device reset pulse first and abort on init_ena drop.
// Optional feature macro: IO_INIT_SPI_READBACK_EN (MISO capture into rx_data).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   init_ena            : level request; init_done high in DONE, busy otherwise
//   bank_sel, do_reset  : bank to play / emit dev_reset first (sampled at start)
//   len0, len1          : word counts per bank (clamped to DEPTH)
//   cfg_we/addr/data    : table write port (addr MSB = bank), ignored while busy
//   dev_reset           : device reset pulse
//   spi_clk/mosi/cs_n   : SPI master outputs; spi_miso readback input
//   rx_data, rx_valid   : captured readback word and one-cycle strobe
module io_init_spi_seq #(
  parameter int WIDTH      = 16,
  parameter int AW         = 5,
  parameter int SCLK_TIME  = 4,
  parameter int CS_GAP     = 8,
  parameter int RST_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_ena,
  output logic             init_done,
  output logic             busy,
  input  logic             bank_sel,
  input  logic             do_reset,
  input  logic [AW:0]      len0,
  input  logic [AW:0]      len1,
  input  logic             cfg_we,
  input  logic [AW:0]      cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic             dev_reset,
  output logic             spi_clk,
  output logic             spi_mosi,
  output logic             spi_cs_n,
  input  logic             spi_miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_LOAD, S_SHIFT, S_GAP, S_DONE
  } state_t;

  localparam int DEPTH = 2**AW;
  localparam int TMAX  = (RST_CYCLES > CS_GAP) ? RST_CYCLES : CS_GAP;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int HW    = $clog2(SCLK_TIME + 1);
  localparam int BW    = $clog2(WIDTH + 1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] mem [0:2*DEPTH-1];
  logic [WIDTH-1:0] shreg;
  logic             bank;
  logic [AW:0]      len_eff;
  logic [AW-1:0]    index;
  logic [TW-1:0]    tcnt;
  logic [HW-1:0]    hcnt;
  logic [BW-1:0]    bitcnt;
  logic             phase;

  logic [AW:0] len_sel, len_in;
  logic        rst_end, gap_end, half_end, word_end, last_idx;

  always_comb begin
    len_sel  = bank_sel ? len1 : len0;
    len_in   = (len_sel > DEPTH_L) ? DEPTH_L : len_sel;
    rst_end  = (tcnt == TW'(RST_CYCLES - 1));
    gap_end  = (tcnt == TW'(CS_GAP - 1));
    half_end = (hcnt == HW'(SCLK_TIME - 1));
    word_end = phase && half_end && (bitcnt == BW'(WIDTH - 1));
    last_idx = ({1'b0, index} == (len_eff - (AW+1)'(1)));
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (init_ena) begin
          if (do_reset)          state_n = S_RESET;
          else if (len_in != '0) state_n = S_LOAD;
          else                   state_n = S_DONE;
        end
      S_RESET:
        if (rst_end) begin
          if (!init_ena)          state_n = S_IDLE;
          else if (len_eff != '0) state_n = S_LOAD;
          else                    state_n = S_DONE;
        end
      S_LOAD:  state_n = S_SHIFT;
      S_SHIFT: if (word_end) state_n = S_GAP;
      S_GAP:
        if (gap_end) begin
          if (!init_ena)    state_n = S_IDLE;
          else if (last_idx) state_n = S_DONE;
          else              state_n = S_LOAD;
        end
      S_DONE:  if (!init_ena) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE) && (state != S_DONE);
    init_done = (state == S_DONE);
    dev_reset = (state == S_RESET);
    spi_cs_n  = (state != S_SHIFT);
    spi_clk   = (state == S_SHIFT) && phase;
    spi_mosi  = (state == S_SHIFT) && shreg[WIDTH-1];
  end

  // Table RAM: no reset, writes only while idle/done.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bank    <= 1'b0;
      len_eff <= '0;
      index   <= '0;
      tcnt    <= '0;
      hcnt    <= '0;
      bitcnt  <= '0;
      phase   <= 1'b0;
      shreg   <= '0;
    end else begin
      state <= state_n;
      // tcnt times RESET and GAP; restarts on every state entry.
      if ((state_n == state) && ((state == S_RESET) || (state == S_GAP)))
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if ((state == S_IDLE) && (state_n != S_IDLE)) begin
        bank    <= bank_sel;
        len_eff <= len_in;
        index   <= '0;
      end
      if ((state == S_GAP) && (state_n == S_LOAD))
        index <= index + AW'(1);
      if (state == S_LOAD) begin
        shreg  <= mem[{bank, index}];
        hcnt   <= '0;
        bitcnt <= '0;
        phase  <= 1'b0;
      end else if (state == S_SHIFT) begin
        if (half_end) begin
          hcnt  <= '0;
          phase <= ~phase;
          // Next bit appears as SCLK falls, so MOSI only moves while SCLK is low.
          if (phase) begin
            shreg  <= {shreg[WIDTH-2:0], 1'b0};
            bitcnt <= bitcnt + BW'(1);
          end
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

`ifdef IO_INIT_SPI_READBACK_EN
  logic [WIDTH-1:0] rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      // Sample on the edge where SCLK goes high.
      if ((state == S_SHIFT) && !phase && half_end)
        rx_sh <= {rx_sh[WIDTH-2:0], spi_miso};
      rx_valid <= (state == S_SHIFT) && (state_n == S_GAP);
      if ((state == S_SHIFT) && (state_n == S_GAP))
        rx_data <= rx_sh;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = spi_miso;
  assign rx_data     = '0;
  assign rx_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_io_init_spi_seq.sv
module tb_io_init_spi_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_ena = 1'b0;
  logic        init_done, busy;
  logic        bank_sel = 1'b0;
  logic        do_reset = 1'b0;
  logic [5:0]  len0 = '0, len1 = '0;
  logic        cfg_we = 1'b0;
  logic [5:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        dev_reset, spi_clk, spi_mosi, spi_cs_n;
  logic        spi_miso = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;

  io_init_spi_seq #(
    .WIDTH(16), .AW(5), .SCLK_TIME(4), .CS_GAP(8), .RST_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .init_ena(init_ena), .init_done(init_done),
    .busy(busy), .bank_sel(bank_sel), .do_reset(do_reset),
    .len0(len0), .len1(len1), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .dev_reset(dev_reset), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave monitor / MISO driver, sampled on the falling clk edge.
  logic [15:0] word_q[$];
  int          cslen_q[$], edge_q[$], fall_q[$];
  int          rst_total = 0, done_total = 0, rxv_total = 0, rx_bad = 0;
  logic [15:0] cur_word = '0;
  logic [15:0] pat = 16'hA5C3;
  int          cur_len = 0, cur_edges = 0;
  logic        prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (dev_reset) rst_total++;
    if (init_done) done_total++;
    if (rx_valid) begin
      rxv_total++;
      if (rx_data !== 16'hA5C3 || !(spi_cs_n && !prev_cs)) rx_bad++;
    end
    if (!spi_cs_n) begin
      if (prev_cs) begin
        fall_q.push_back(cyc);
        cur_len = 0; cur_edges = 0; cur_word = '0;
      end
      cur_len++;
      if (spi_clk && !prev_sclk) begin
        cur_word = {cur_word[14:0], spi_mosi};
        cur_edges++;
      end
    end else if (!prev_cs) begin
      word_q.push_back(cur_word);
      cslen_q.push_back(cur_len);
      edge_q.push_back(cur_edges);
    end
    spi_miso  = (cur_edges < 16) ? pat[15 - cur_edges] : 1'b0;
    prev_cs   = spi_cs_n;
    prev_sclk = spi_clk;
  end

  int n_tests = 0, n_fail = 0;
  logic [15:0] model [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [15:0] data);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    model[addr] = data;
  endtask

  task automatic wait_cs_low(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!spi_cs_n) begin ok = 1; break; end
    end
    chk("cs_low_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  typedef struct {
    logic       bank;
    logic       do_rst;
    logic [5:0] l0;
    logic [5:0] l1;
    int         exp_words;
    int         exp_rst;
  } vec_t;

  task automatic run_case(input vec_t v);
    int s_w, s_r, s_rx, s_bad, t0, td, bad_d, bad_l, bad_e, got;
    bit ok;
    s_w = word_q.size(); s_r = rst_total; s_rx = rxv_total; s_bad = rx_bad;
    @(negedge clk);
    bank_sel = v.bank; do_reset = v.do_rst; len0 = v.l0; len1 = v.l1;
    init_ena = 1'b1;
    t0 = cyc; td = 0; ok = 0;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (init_done) begin ok = 1; td = cyc; break; end
    end
    chk("done_timeout", 32'(ok), 32'd1);
    chk("done_delay", 32'(td - t0),
        32'(1 + (v.do_rst ? 16 : 0) + v.exp_words * 137));
    got = word_q.size() - s_w;
    chk("word_count", 32'(got), 32'(v.exp_words));
    chk("rst_cycles", 32'(rst_total - s_r), 32'(v.exp_rst));
    bad_d = 0; bad_l = 0; bad_e = 0;
    for (int i = 0; i < got && i < v.exp_words; i++) begin
      if (word_q[s_w + i] !== model[(v.bank ? 32 : 0) + i]) bad_d++;
      if (cslen_q[s_w + i] != 128) bad_l++;
      if (edge_q[s_w + i] != 16) bad_e++;
    end
    chk("word_data_errs", 32'(bad_d), 32'd0);
    chk("cs_len_errs", 32'(bad_l), 32'd0);
    chk("sclk_edge_errs", 32'(bad_e), 32'd0);
    if (got > 0)
      chk("first_cs_delay", 32'(fall_q[s_w] - t0), 32'(2 + (v.do_rst ? 16 : 0)));
`ifdef IO_INIT_SPI_READBACK_EN
    chk("rx_valid_count", 32'(rxv_total - s_rx), 32'(v.exp_words));
    chk("rx_bad", 32'(rx_bad - s_bad), 32'd0);
`else
    chk("rx_valid_count", 32'(rxv_total - s_rx), 32'd0);
    chk("rx_data_zero", 32'(rx_data), 32'd0);
`endif
    init_ena = 1'b0;
    @(negedge clk);
    chk("idle_after_drop", {30'd0, busy, init_done}, 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int s_w, s_r, s_d;
    vecs[0] = '{bank: 1'b0, do_rst: 1'b1, l0: 6'd3,  l1: 6'd0,  exp_words: 3,  exp_rst: 16};
    vecs[1] = '{bank: 1'b1, do_rst: 1'b0, l0: 6'd0,  l1: 6'd2,  exp_words: 2,  exp_rst: 0};
    vecs[2] = '{bank: 1'b0, do_rst: 1'b0, l0: 6'd0,  l1: 6'd2,  exp_words: 0,  exp_rst: 0};
    vecs[3] = '{bank: 1'b0, do_rst: 1'b0, l0: 6'd63, l1: 6'd0,  exp_words: 32, exp_rst: 0};
    vecs[4] = '{bank: 1'b1, do_rst: 1'b1, l0: 6'd5,  l1: 6'd0,  exp_words: 0,  exp_rst: 16};
    vecs[5] = '{bank: 1'b1, do_rst: 1'b0, l0: 6'd0,  l1: 6'd32, exp_words: 32, exp_rst: 0};

    repeat (3) @(negedge clk);
    chk("rst_outputs",
        {25'd0, init_done, busy, dev_reset, spi_clk, spi_mosi, spi_cs_n, rx_valid},
        32'b10);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      wr(i, {8'(i), 8'(~i)});
      wr(32 + i, {8'(i + 64), 8'hC3});
    end
    wr(0, 16'h0080); wr(1, 16'h2000); wr(2, 16'h3F00);
    wr(32, 16'h6200); wr(33, 16'h7500);

    foreach (vecs[i]) run_case(vecs[i]);

    // Abort during word 2 of 5; write attempted while busy must be dropped.
    s_w = word_q.size(); s_d = done_total;
    @(negedge clk);
    bank_sel = 1'b0; do_reset = 1'b0; len0 = 6'd5; init_ena = 1'b1;
    wait_cs_low(50);
    for (int k = 0; k < 300 && word_q.size() == s_w; k++) @(negedge clk);
    wait_cs_low(50);
    repeat (10) @(negedge clk);
    init_ena = 1'b0;
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_data = 16'hDEAD;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_idle(400);
    chk("abort_words", 32'(word_q.size() - s_w), 32'd2);
    if (word_q.size() >= s_w + 2) begin
      chk("abort_word2", 32'(word_q[s_w + 1]), 32'(model[1]));
      chk("abort_word2_len", 32'(cslen_q[s_w + 1]), 32'd128);
    end
    repeat (50) @(negedge clk);
    chk("abort_no_more", 32'(word_q.size() - s_w), 32'd2);
    chk("abort_no_done", 32'(done_total - s_d), 32'd0);
    run_case('{bank: 1'b0, do_rst: 1'b0, l0: 6'd1, l1: 6'd0, exp_words: 1, exp_rst: 0});

    // Abort during the reset pulse: pulse completes, then straight to IDLE.
    s_w = word_q.size(); s_r = rst_total; s_d = done_total;
    @(negedge clk);
    bank_sel = 1'b0; do_reset = 1'b1; len0 = 6'd3; init_ena = 1'b1;
    repeat (5) @(negedge clk);
    init_ena = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    chk("rst_abort_pulse", 32'(rst_total - s_r), 32'd16);
    chk("rst_abort_words", 32'(word_q.size() - s_w), 32'd0);
    chk("rst_abort_no_done", 32'(done_total - s_d), 32'd0);

    // Synchronous reset in the middle of word 2, then restart from index 0.
    s_w = word_q.size();
    @(negedge clk);
    bank_sel = 1'b0; do_reset = 1'b0; len0 = 6'd3; init_ena = 1'b1;
    wait_cs_low(50);
    for (int k = 0; k < 300 && word_q.size() == s_w; k++) @(negedge clk);
    wait_cs_low(50);
    repeat (20) @(negedge clk);
    rst = 1'b1; init_ena = 1'b0;
    @(negedge clk);
    chk("midrst_outputs",
        {27'd0, busy, init_done, dev_reset, spi_clk, spi_cs_n}, 32'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_case('{bank: 1'b0, do_rst: 1'b0, l0: 6'd1, l1: 6'd0, exp_words: 1, exp_rst: 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
